// File: rtl/sram_arbiter.sv
// Two-port arbiter and pin sequencer for one asynchronous 256Kx16 SRAM.
// The host port has priority; the secondary port is guaranteed a slot after MAX_DEFER host grants.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 32'd2,
  parameter int unsigned MAX_DEFER   = 32'd4,
  parameter int unsigned ADDR_W      = 32'd18,
  parameter int unsigned DATA_W      = 32'd16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hst_req,
  input  logic              hst_we,
  input  logic [ADDR_W-1:0] hst_addr,
  input  logic [DATA_W-1:0] hst_wdata,
  input  logic              hst_abort,
  output logic              hst_ack,
  output logic [DATA_W-1:0] hst_rdata,
  input  logic              sec_req,
  input  logic              sec_we,
  input  logic [ADDR_W-1:0] sec_addr,
  input  logic [DATA_W-1:0] sec_wdata,
  output logic              sec_ack,
  output logic [DATA_W-1:0] sec_rdata,
  output logic [ADDR_W-1:0] address_pins,
  input  logic [DATA_W-1:0] sram_data_in,
  output logic [DATA_W-1:0] sram_data_out,
  output logic              sram_data_out_en,
  output logic              RAMCS,
  output logic              RAMOE,
  output logic              RAMWE,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 32'd1);
  localparam logic [3:0] DEFER_MAX = 4'(MAX_DEFER);

  state_t              state_r;
  logic [3:0]          wait_cnt_r;
  logic [3:0]          defer_cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                we_r;
  logic                owner_r;
  logic                last_sec_r;
  logic                abort_seen_r;
  logic                hst_ack_r;
  logic                sec_ack_r;
  logic [DATA_W-1:0]   hst_rdata_r;
  logic [DATA_W-1:0]   sec_rdata_r;
  logic                dout_en_r;
  logic                ramcs_r;
  logic                ramoe_r;
  logic                ramwe_r;

  logic                hst_live_s;
  logic                sec_force_s;
  logic                sec_win_s;
  logic                hst_win_s;
  logic                hst_abort_own_s;
  logic                next_we_s;
  logic [ADDR_W-1:0]   next_addr_s;
  logic [DATA_W-1:0]   next_wdata_s;

  // A host request raised together with abort is not a request. The forced secondary
  // slot is skipped right after a secondary grant, which gives alternation at MAX_DEFER=0.
  assign hst_live_s      = hst_req & ~hst_abort;
  assign sec_force_s     = (defer_cnt_r == DEFER_MAX) & ~last_sec_r;
  assign sec_win_s       = sec_req & (~hst_live_s | sec_force_s);
  assign hst_win_s       = hst_live_s & ~sec_win_s;
  assign hst_abort_own_s = hst_abort & ~owner_r;
  assign next_we_s       = sec_win_s ? sec_we    : hst_we;
  assign next_addr_s     = sec_win_s ? sec_addr  : hst_addr;
  assign next_wdata_s    = sec_win_s ? sec_wdata : hst_wdata;

  assign hst_ack          = hst_ack_r & ~hst_abort;
  assign sec_ack          = sec_ack_r;
  assign hst_rdata        = hst_rdata_r;
  assign sec_rdata        = sec_rdata_r;
  assign address_pins     = addr_r;
  assign sram_data_out    = wdata_r;
  assign sram_data_out_en = dout_en_r;
  assign RAMCS            = ramcs_r;
  assign RAMOE            = ramoe_r;
  assign RAMWE            = ramwe_r;
  assign busy             = (state_r != IDLE);
  assign owner            = owner_r;

  // Sequencer: arbitration, SRAM pin timing and completion pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      wait_cnt_r   <= 4'd0;
      defer_cnt_r  <= 4'd0;
      addr_r       <= '0;
      wdata_r      <= '0;
      we_r         <= 1'b0;
      owner_r      <= 1'b0;
      last_sec_r   <= 1'b0;
      abort_seen_r <= 1'b0;
      hst_ack_r    <= 1'b0;
      sec_ack_r    <= 1'b0;
      hst_rdata_r  <= '0;
      sec_rdata_r  <= '0;
      dout_en_r    <= 1'b0;
      ramcs_r      <= 1'b1;
      ramoe_r      <= 1'b1;
      ramwe_r      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (sec_win_s || hst_win_s) begin
            state_r      <= SETUP;
            owner_r      <= sec_win_s;
            last_sec_r   <= sec_win_s;
            we_r         <= next_we_s;
            addr_r       <= next_addr_s;
            wdata_r      <= next_wdata_s;
            ramcs_r      <= 1'b0;
            ramoe_r      <= next_we_s;
            dout_en_r    <= next_we_s;
            wait_cnt_r   <= WAIT_LAST;
            abort_seen_r <= 1'b0;
            if (sec_win_s) begin
              defer_cnt_r <= 4'd0;
            end else if (sec_req && (defer_cnt_r != DEFER_MAX)) begin
              defer_cnt_r <= defer_cnt_r + 4'd1;
            end else begin
              defer_cnt_r <= defer_cnt_r;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          if (hst_abort_own_s) begin
            state_r   <= IDLE;
            ramcs_r   <= 1'b1;
            ramoe_r   <= 1'b1;
            dout_en_r <= 1'b0;
          end else begin
            state_r <= ACCESS;
            ramwe_r <= ~we_r;
          end
        end
        ACCESS: begin
          abort_seen_r <= abort_seen_r | hst_abort_own_s;
          if (wait_cnt_r == 4'd0) begin
            state_r   <= RECOVER;
            ramwe_r   <= 1'b1;
            ramoe_r   <= 1'b1;
            sec_ack_r <= owner_r;
            hst_ack_r <= ~owner_r & ~abort_seen_r & ~hst_abort;
            if (!we_r && owner_r) begin
              sec_rdata_r <= sram_data_in;
            end else if (!we_r) begin
              hst_rdata_r <= sram_data_in;
            end else begin
              hst_rdata_r <= hst_rdata_r;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        RECOVER: begin
          // CS, address and write data were held through this cycle for hold/turnaround.
          state_r   <= IDLE;
          hst_ack_r <= 1'b0;
          sec_ack_r <= 1'b0;
          ramcs_r   <= 1'b1;
          dout_en_r <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: pin timing, fairness, abort, reset and latency for several WAIT_CYCLES.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hst_req, hst_we, hst_abort, hst_ack;
  logic [17:0] hst_addr;
  logic [15:0] hst_wdata, hst_rdata;
  logic        sec_req, sec_we, sec_ack;
  logic [17:0] sec_addr;
  logic [15:0] sec_wdata, sec_rdata;
  logic [17:0] address_pins;
  logic [15:0] sram_data_in, sram_data_out;
  logic        sram_data_out_en, RAMCS, RAMOE, RAMWE, busy, owner;

  // second and third builds (WAIT_CYCLES 1 and 15) for latency checks
  logic        r1, r15, tie0;
  logic [15:0] const_din;
  logic        w1_ack, w1_sack, w1_doen, w1_cs, w1_oe, w1_we, w1_busy, w1_owner;
  logic [15:0] w1_rdata, w1_srdata, w1_dout;
  logic [17:0] w1_addr;
  logic        w15_ack, w15_sack, w15_doen, w15_cs, w15_oe, w15_we, w15_busy, w15_owner;
  logic [15:0] w15_rdata, w15_srdata, w15_dout;
  logic [17:0] w15_addr;

  logic [15:0] mem [0:4095];
  int n_cmp;
  int n_err;

  always #5 clk = ~clk;

  always_comb sram_data_in = (!RAMCS && !RAMOE) ? mem[address_pins[11:0]] : 16'h0000;

  always @(posedge RAMWE) begin
    if (!RAMCS) mem[address_pins[11:0]] = sram_data_out;
  end

  sram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .hst_req(hst_req), .hst_we(hst_we), .hst_addr(hst_addr), .hst_wdata(hst_wdata),
    .hst_abort(hst_abort), .hst_ack(hst_ack), .hst_rdata(hst_rdata),
    .sec_req(sec_req), .sec_we(sec_we), .sec_addr(sec_addr), .sec_wdata(sec_wdata),
    .sec_ack(sec_ack), .sec_rdata(sec_rdata),
    .address_pins(address_pins), .sram_data_in(sram_data_in), .sram_data_out(sram_data_out),
    .sram_data_out_en(sram_data_out_en), .RAMCS(RAMCS), .RAMOE(RAMOE), .RAMWE(RAMWE),
    .busy(busy), .owner(owner)
  );

  sram_arbiter #(.WAIT_CYCLES(32'd1)) u_w1 (
    .clk(clk), .reset_n(reset_n),
    .hst_req(r1), .hst_we(hst_we), .hst_addr(hst_addr), .hst_wdata(hst_wdata),
    .hst_abort(hst_abort), .hst_ack(w1_ack), .hst_rdata(w1_rdata),
    .sec_req(tie0), .sec_we(tie0), .sec_addr(sec_addr), .sec_wdata(sec_wdata),
    .sec_ack(w1_sack), .sec_rdata(w1_srdata),
    .address_pins(w1_addr), .sram_data_in(const_din), .sram_data_out(w1_dout),
    .sram_data_out_en(w1_doen), .RAMCS(w1_cs), .RAMOE(w1_oe), .RAMWE(w1_we),
    .busy(w1_busy), .owner(w1_owner)
  );

  sram_arbiter #(.WAIT_CYCLES(32'd15)) u_w15 (
    .clk(clk), .reset_n(reset_n),
    .hst_req(r15), .hst_we(hst_we), .hst_addr(hst_addr), .hst_wdata(hst_wdata),
    .hst_abort(hst_abort), .hst_ack(w15_ack), .hst_rdata(w15_rdata),
    .sec_req(tie0), .sec_we(tie0), .sec_addr(sec_addr), .sec_wdata(sec_wdata),
    .sec_ack(w15_sack), .sec_rdata(w15_srdata),
    .address_pins(w15_addr), .sram_data_in(const_din), .sram_data_out(w15_dout),
    .sram_data_out_en(w15_doen), .RAMCS(w15_cs), .RAMOE(w15_oe), .RAMWE(w15_we),
    .busy(w15_busy), .owner(w15_owner)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if ({RAMCS, RAMOE, RAMWE} !== 3'b111) begin n_err++; $display("FAIL rst_strobes got %b want 111", {RAMCS, RAMOE, RAMWE}); end
    n_cmp++; if ({sram_data_out_en, hst_ack, sec_ack, busy, owner} !== 5'b00000) begin n_err++; $display("FAIL rst_flags got %b want 00000", {sram_data_out_en, hst_ack, sec_ack, busy, owner}); end
    n_cmp++; if (address_pins !== 18'h00000) begin n_err++; $display("FAIL rst_addr got %h want 00000", address_pins); end
    n_cmp++; if ({sram_data_out, hst_rdata, sec_rdata} !== 48'h0) begin n_err++; $display("FAIL rst_data got %h want 0", {sram_data_out, hst_rdata, sec_rdata}); end
  endtask

  task automatic test_host_read();
    logic [5:1] e_cs, e_oe, e_ack;
    e_cs = 5'b10000; e_oe = 5'b11000; e_ack = 5'b01000;
    mem[12'h234] = 16'hBEEF;
    @(negedge clk);
    hst_we = 1'b0; hst_addr = 18'h01234; hst_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_cmp++; if (RAMCS !== e_cs[k]) begin n_err++; $display("FAIL rd_cs cycle %0d got %b want %b", k, RAMCS, e_cs[k]); end
      n_cmp++; if (RAMOE !== e_oe[k]) begin n_err++; $display("FAIL rd_oe cycle %0d got %b want %b", k, RAMOE, e_oe[k]); end
      n_cmp++; if (RAMWE !== 1'b1) begin n_err++; $display("FAIL rd_we cycle %0d got %b want 1", k, RAMWE); end
      n_cmp++; if (hst_ack !== e_ack[k]) begin n_err++; $display("FAIL rd_ack cycle %0d got %b want %b", k, hst_ack, e_ack[k]); end
      if (k <= 4) begin
        n_cmp++; if (address_pins !== 18'h01234) begin n_err++; $display("FAIL rd_addr cycle %0d got %h want 01234", k, address_pins); end
      end
      if (k == 4) begin
        n_cmp++; if (hst_rdata !== 16'hBEEF) begin n_err++; $display("FAIL rd_data got %h want beef", hst_rdata); end
        hst_req = 1'b0;
      end
    end
  endtask

  task automatic test_host_write();
    logic [5:1] e_cs, e_we, e_en, e_ack;
    e_cs = 5'b10000; e_we = 5'b11001; e_en = 5'b01111; e_ack = 5'b01000;
    mem[12'hFFF] = 16'h0000;
    @(negedge clk);
    hst_we = 1'b1; hst_addr = 18'h3FFFF; hst_wdata = 16'hA55A; hst_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_cmp++; if (RAMCS !== e_cs[k]) begin n_err++; $display("FAIL wr_cs cycle %0d got %b want %b", k, RAMCS, e_cs[k]); end
      n_cmp++; if (RAMWE !== e_we[k]) begin n_err++; $display("FAIL wr_we cycle %0d got %b want %b", k, RAMWE, e_we[k]); end
      n_cmp++; if (RAMOE !== 1'b1) begin n_err++; $display("FAIL wr_oe cycle %0d got %b want 1", k, RAMOE); end
      n_cmp++; if (sram_data_out_en !== e_en[k]) begin n_err++; $display("FAIL wr_en cycle %0d got %b want %b", k, sram_data_out_en, e_en[k]); end
      n_cmp++; if (hst_ack !== e_ack[k]) begin n_err++; $display("FAIL wr_ack cycle %0d got %b want %b", k, hst_ack, e_ack[k]); end
      if (k <= 4) begin
        n_cmp++; if ({address_pins, sram_data_out} !== {18'h3FFFF, 16'hA55A}) begin n_err++; $display("FAIL wr_addr_data cycle %0d got %h/%h want 3ffff/a55a", k, address_pins, sram_data_out); end
      end
      if (k == 4) hst_req = 1'b0;
    end
    n_cmp++; if (mem[12'hFFF] !== 16'hA55A) begin n_err++; $display("FAIL wr_mem got %h want a55a", mem[12'hFFF]); end
  endtask

  task automatic test_fairness();
    logic [9:0] e_sec;
    int g, hi, si;
    e_sec = 10'b1000010000;
    g = 0; hi = 0; si = 0;
    for (int i = 0; i < 8; i++) mem[12'h100 + 12'(i)] = 16'h1000 + 16'(i);
    for (int i = 0; i < 2; i++) mem[12'h200 + 12'(i)] = 16'h2000 + 16'(i);
    @(negedge clk);
    hst_we = 1'b0; sec_we = 1'b0; hst_addr = 18'h00100; sec_addr = 18'h00200;
    hst_req = 1'b1; sec_req = 1'b1;
    for (int c = 0; c < 70 && g < 10; c++) begin
      @(negedge clk);
      n_cmp++; if (hst_ack === 1'b1 && sec_ack === 1'b1) begin n_err++; $display("FAIL fair_overlap cycle %0d got both acks want one", c); end
      if (hst_ack === 1'b1) begin
        n_cmp++; if (e_sec[g] !== 1'b0) begin n_err++; $display("FAIL fair_order grant %0d got H want S", g); end
        n_cmp++; if (hst_rdata !== 16'h1000 + 16'(hi)) begin n_err++; $display("FAIL fair_hdata got %h want %h", hst_rdata, 16'h1000 + 16'(hi)); end
        hi++; g++;
        hst_addr = 18'h00100 + 18'(hi);
      end else if (sec_ack === 1'b1) begin
        n_cmp++; if (e_sec[g] !== 1'b1) begin n_err++; $display("FAIL fair_order grant %0d got S want H", g); end
        n_cmp++; if (sec_rdata !== 16'h2000 + 16'(si)) begin n_err++; $display("FAIL fair_sdata got %h want %h", sec_rdata, 16'h2000 + 16'(si)); end
        si++; g++;
        sec_addr = 18'h00200 + 18'(si);
      end
    end
    hst_req = 1'b0; sec_req = 1'b0;
    n_cmp++; if (g !== 10) begin n_err++; $display("FAIL fair_count got %0d grants want 10", g); end
  endtask

  task automatic test_abort_setup();
    mem[12'h050] = 16'hDEAD;
    @(negedge clk);
    hst_we = 1'b1; hst_addr = 18'h00050; hst_wdata = 16'h1234; hst_req = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy, RAMCS} !== 2'b10) begin n_err++; $display("FAIL abs_setup got busy/cs %b want 10", {busy, RAMCS}); end
    hst_abort = 1'b1; hst_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, RAMCS, sram_data_out_en} !== 3'b010) begin n_err++; $display("FAIL abs_idle got busy/cs/en %b want 010", {busy, RAMCS, sram_data_out_en}); end
    hst_abort = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      if (k > 2) @(negedge clk);
      n_cmp++; if ({RAMWE, hst_ack} !== 2'b10) begin n_err++; $display("FAIL abs_quiet cycle %0d got we/ack %b want 10", k, {RAMWE, hst_ack}); end
    end
    n_cmp++; if (mem[12'h050] !== 16'hDEAD) begin n_err++; $display("FAIL abs_mem got %h want dead", mem[12'h050]); end
  endtask

  task automatic test_abort_access();
    mem[12'h060] = 16'h0000;
    @(negedge clk);
    hst_we = 1'b1; hst_addr = 18'h00060; hst_wdata = 16'h5678; hst_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (RAMWE !== 1'b0) begin n_err++; $display("FAIL aba_we2 got %b want 0", RAMWE); end
    hst_abort = 1'b1;
    @(negedge clk);
    hst_abort = 1'b0;
    n_cmp++; if (RAMWE !== 1'b0) begin n_err++; $display("FAIL aba_we3 got %b want 0", RAMWE); end
    @(negedge clk);
    n_cmp++; if ({busy, RAMWE, hst_ack} !== 3'b110) begin n_err++; $display("FAIL aba_recover got busy/we/ack %b want 110", {busy, RAMWE, hst_ack}); end
    hst_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, hst_ack} !== 2'b00) begin n_err++; $display("FAIL aba_idle got busy/ack %b want 00", {busy, hst_ack}); end
    n_cmp++; if (mem[12'h060] !== 16'h5678) begin n_err++; $display("FAIL aba_mem got %h want 5678", mem[12'h060]); end
  endtask

  task automatic test_reset_mid_write();
    logic [5:1] e_ack;
    e_ack = 5'b01000;
    mem[12'h080] = 16'h8888;
    @(negedge clk);
    hst_we = 1'b1; hst_addr = 18'h00070; hst_wdata = 16'h7777; hst_req = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (RAMWE !== 1'b0) begin n_err++; $display("FAIL rmw_we_pre got %b want 0", RAMWE); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({RAMWE, RAMCS, busy, sram_data_out_en} !== 4'b1100) begin n_err++; $display("FAIL rmw_async got we/cs/busy/en %b want 1100", {RAMWE, RAMCS, busy, sram_data_out_en}); end
    n_cmp++; if (hst_rdata !== 16'h0000) begin n_err++; $display("FAIL rmw_rdata got %h want 0000", hst_rdata); end
    hst_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sec_we = 1'b0; sec_addr = 18'h00080; sec_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_cmp++; if (sec_ack !== e_ack[k]) begin n_err++; $display("FAIL rmw_sack cycle %0d got %b want %b", k, sec_ack, e_ack[k]); end
      if (k == 4) begin
        n_cmp++; if (sec_rdata !== 16'h8888) begin n_err++; $display("FAIL rmw_sdata got %h want 8888", sec_rdata); end
        sec_req = 1'b0;
      end
    end
  endtask

  task automatic test_latency();
    int a1, b1, a15, b15;
    a1 = 0; b1 = 0; a15 = 0; b15 = 0;
    @(negedge clk);
    hst_we = 1'b0; hst_addr = 18'h00010; r1 = 1'b1; r15 = 1'b1;
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      if (w1_ack === 1'b1) begin
        if (a1 == 0) begin
          a1 = k;
          n_cmp++; if (w1_rdata !== 16'hC3C3) begin n_err++; $display("FAIL lat1_data got %h want c3c3", w1_rdata); end
        end else if (b1 == 0) begin
          b1 = k;
        end
      end
      if (w15_ack === 1'b1) begin
        if (a15 == 0) begin
          a15 = k;
          n_cmp++; if (w15_rdata !== 16'hC3C3) begin n_err++; $display("FAIL lat15_data got %h want c3c3", w15_rdata); end
        end else if (b15 == 0) begin
          b15 = k;
        end
      end
      if (k == 7) r1 = 1'b0;
      if (k == 35) r15 = 1'b0;
    end
    n_cmp++; if (a1 !== 3) begin n_err++; $display("FAIL lat1_first got cycle %0d want 3", a1); end
    n_cmp++; if (b1 !== 7) begin n_err++; $display("FAIL lat1_second got cycle %0d want 7", b1); end
    n_cmp++; if (a15 !== 17) begin n_err++; $display("FAIL lat15_first got cycle %0d want 17", a15); end
    n_cmp++; if (b15 !== 35) begin n_err++; $display("FAIL lat15_second got cycle %0d want 35", b15); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset_n = 1'b0;
    hst_req = 1'b0; hst_we = 1'b0; hst_addr = 18'h0; hst_wdata = 16'h0; hst_abort = 1'b0;
    sec_req = 1'b0; sec_we = 1'b0; sec_addr = 18'h0; sec_wdata = 16'h0;
    r1 = 1'b0; r15 = 1'b0; tie0 = 1'b0; const_din = 16'hC3C3;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    test_host_read();
    test_host_write();
    test_fairness();
    test_abort_setup();
    test_abort_access();
    test_reset_mid_write();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences and shares the single external 256Kx16 SRAM between two requesters.
- Host port (CPU memory cycles from the memory interface) has priority.
- Secondary port (DSR/GROM image loader, DMA) is served in idle slots; bounded-deferral fairness prevents starvation.
- Owns all SRAM pin timing (CS/OE/WE, address/data hold, bus turnaround). Requesters see only a req/ack handshake.

Parameters:
WAIT_CYCLES, 2, number of ACCESS-state cycles (SRAM access time in clk periods); legal 1..15
MAX_DEFER, 4, consecutive host grants allowed while secondary is pending before the secondary wins; legal 0..15
ADDR_W, 18, SRAM word address width
DATA_W, 16, SRAM data width

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
hst_req  input  1  host request, level; held with stable inputs until hst_ack
hst_we  input  1  host direction; 1 = write, 0 = read
hst_addr  input  ADDR_W  host word address (bank-mapped)
hst_wdata  input  DATA_W  host write data
hst_abort  input  1  host cycle aborted (memen rose); see Behaviour
hst_ack  output  1  one-cycle completion pulse; hst_rdata valid in same cycle
hst_rdata  output  DATA_W  host read data, held until next host read completes
sec_req  input  1  secondary request, level
sec_we  input  1  secondary direction
sec_addr  input  ADDR_W  secondary word address
sec_wdata  input  DATA_W  secondary write data
sec_ack  output  1  one-cycle completion pulse
sec_rdata  output  DATA_W  secondary read data, held until next secondary read completes
address_pins  output  ADDR_W  SRAM address
sram_data_in  input  DATA_W  SRAM data pins, input side
sram_data_out  output  DATA_W  SRAM data pins, output side
sram_data_out_en  output  1  1 = FPGA drives SRAM data pins
RAMCS  output  1  chip select, active low
RAMOE  output  1  output enable, active low
RAMWE  output  1  write enable, active low
busy  output  1  1 when state != IDLE
owner  output  1  0 = host, 1 = secondary; valid while busy

Behaviour:
- Reset (async, reset_n low):
  - State IDLE.
  - RAMCS, RAMOE and RAMWE are 1.
  - sram_data_out_en, hst_ack, sec_ack, busy and owner are 0.
  - address_pins, sram_data_out, hst_rdata, sec_rdata and defer_cnt are 0.
  - Reset mid-write deasserts RAMWE immediately; the SRAM word content is then undefined.
- States: IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> RECOVER -> IDLE. No pipelining: one access in flight.
- IDLE arbitration, per edge:
  - Secondary wins if sec_req=1 and (hst_req=0 or defer_cnt==MAX_DEFER).
  - Otherwise host wins if hst_req=1.
  - Winner's addr, we and wdata are latched into internal regs; owner is set; go to SETUP.
  - Host grant while sec_req=1: defer_cnt increments, saturating at MAX_DEFER.
  - Any secondary grant: defer_cnt clears to 0.
- SETUP (1 cycle): RAMCS=0, address_pins = latched addr.
  - Read: RAMOE=0.
  - Write: sram_data_out_en=1, sram_data_out = latched wdata. RAMWE stays 1 (address setup before WE).
- ACCESS (WAIT_CYCLES cycles, 4-bit down-counter):
  - Write: RAMWE=0 for the whole state.
  - Read: RAMOE=0; sram_data_in is captured into the owner's rdata reg on the last ACCESS cycle.
- RECOVER (1 cycle):
  - RAMWE=1 and RAMOE=1.
  - RAMCS, address and write data are held (write data hold; read-to-write turnaround).
  - The owner's ack is 1 for this cycle only.
- Back in IDLE: RAMCS=1, sram_data_out_en=0.
- Latency: request sampled at edge N -> ack high in cycle N+2+WAIT_CYCLES.
  - Back-to-back throughput: one access per WAIT_CYCLES+3 cycles.
- Handshake:
  - Requester holds req and inputs stable until ack.
  - Requester drops req in the cycle after ack. A req still high in IDLE after ack is a new request.
  - Inputs changing while owner is busy have no effect (latched copy is used).
- hst_abort:
  - In SETUP with owner=host: go to IDLE next edge, no ack, RAMWE never asserted.
  - In ACCESS/RECOVER: the access completes normally but hst_ack is suppressed.
  - In IDLE, or when owner=secondary: ignored.
- Simultaneous hst_req and sec_req with defer_cnt<MAX_DEFER: host wins.
  - MAX_DEFER=0: strict alternation whenever both are pending.
- hst_req and hst_abort both high in IDLE: no grant to host; secondary may be granted.

Test Plan:
- Host read, WAIT_CYCLES=2: hst_req at edge 0, addr 0x01234, SRAM model returns 0xBEEF -> RAMCS low cycles 1-4, RAMOE low cycles 1-3, hst_ack only in cycle 4, hst_rdata=0xBEEF, RAMWE never low.
- Host write addr 0x3FFFF data 0xA55A -> RAMWE low exactly cycles 2-3; address and data stable and sram_data_out_en=1 cycles 1-4; model holds 0xA55A; ack cycle 4.
- Both requesters held continuously, MAX_DEFER=4 -> grant order H,H,H,H,S,H,H,H,H,S; no ack overlap; sec_rdata/hst_rdata each track their own reads.
- hst_abort in SETUP of a write -> no RAMWE pulse, no hst_ack, IDLE next edge. Abort during ACCESS -> write completes, hst_ack stays 0.
- reset_n low during ACCESS of a write -> same-instant RAMWE=1, RAMCS=1, busy=0. After release, a secondary read is serviced with sec_ack 4 cycles later.
- WAIT_CYCLES=1 and 15 builds: ack latency 3 and 17 cycles respectively. req left high after ack -> second access starts on the following edge.
